// File: rtl/spi_pkg.sv
// spi_pkg: shared byte width and sequencer state encoding
// for the SPI burst sequencer slice.
package spi_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_GAP   = 2'd3
  } seq_state_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// spi_sync_fifo: single-clock FIFO with occupancy count and
// a synchronous flush that wins over push and pop.
module spi_sync_fifo
  import spi_pkg::*;
#(
  parameter int WIDTH = BYTE_W,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  // Head reads as zero when empty so reset leaves the output clean.
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (i_rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/spi_burst_sequencer.sv
// spi_burst_sequencer: feeds host bytes to a single-byte SPI
// master one at a time and queues the bytes it returns.
module spi_burst_sequencer
  import spi_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_tx_valid,
  input  logic [BYTE_W-1:0] i_tx_data,
  output logic              o_tx_ready,
  output logic              o_rx_valid,
  output logic [BYTE_W-1:0] o_rx_data,
  input  logic              i_rx_ready,
  input  logic              i_flush,
  output logic              o_busy,
  output logic [LW-1:0]     o_tx_level,
  output logic [LW-1:0]     o_rx_level,
  output logic              o_timeout,
  output logic              o_start_tx,
  output logic [BYTE_W-1:0] o_tx_byte,
  input  logic              i_tx_done,
  input  logic [BYTE_W-1:0] i_rx_byte
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  seq_state_t        state;
  seq_state_t        state_nx;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nx;
  logic              drop;
  logic              drop_nx;
  logic              to_hit;
  logic              tx_pop;
  logic              rx_push;
  logic              tx_push;
  logic              tx_full;
  logic              tx_empty;
  logic              rx_full;
  logic              rx_empty;
  logic [BYTE_W-1:0] tx_head;

  assign o_tx_ready = !tx_full && !i_flush;
  assign tx_push    = i_tx_valid && o_tx_ready;
  assign o_rx_valid = !rx_empty;
  assign o_start_tx = (state == S_START);
  assign o_busy     = (state != S_IDLE) || !tx_empty;

  spi_sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .flush (i_flush),
    .push  (tx_push),
    .din   (i_tx_data),
    .pop   (tx_pop),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .level (o_tx_level)
  );

  spi_sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .flush (i_flush),
    .push  (rx_push),
    .din   (i_rx_byte),
    .pop   (i_rx_ready),
    .dout  (o_rx_data),
    .full  (rx_full),
    .empty (rx_empty),
    .level (o_rx_level)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    drop_nx  = drop;
    to_hit   = 1'b0;
    tx_pop   = 1'b0;
    rx_push  = 1'b0;
    unique case (state)
      S_IDLE: begin
        // Launch only with RX space reserved for the reply.
        if (!tx_empty && !rx_full && !i_flush) begin
          state_nx = S_START;
          tx_pop   = 1'b1;
          drop_nx  = 1'b0;
        end
      end
      S_START: begin
        state_nx = S_WAIT;
        cnt_nx   = '0;
      end
      S_WAIT: begin
        if (i_tx_done) begin
          rx_push  = !drop;
          state_nx = S_GAP;
          cnt_nx   = '0;
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          to_hit   = 1'b1;
          state_nx = S_GAP;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt == CW'(GAP_CYCLES - 1)) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    // A flush with a byte in flight orphans its reply.
    if (i_flush && (state == S_START || state == S_WAIT)) begin
      drop_nx = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      drop      <= 1'b0;
      o_timeout <= 1'b0;
      o_tx_byte <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      drop  <= drop_nx;
      if (to_hit)       o_timeout <= 1'b1;
      else if (i_flush) o_timeout <= 1'b0;
      if (tx_pop) o_tx_byte <= tx_head;
    end
  end

endmodule
